// File: rtl/ahb_master_port.sv
// ahb_master_port
// Bus-master front end for one slot of the round-robin AHB arbiter. Local
// commands are queued in a small FIFO and issued as AHB single transfers
// while the grant is held. Every completed transfer returns a one-cycle
// response.
//
// Ports
//   HCLK, HRESET            clock, asynchronous active-high reset
//   cmd_valid/cmd_ready     command handshake (accepted on valid & ready)
//   cmd_write/addr/wdata    command contents
//   rsp_valid/rsp_rdata     one-cycle completion pulse, read data (0 for writes)
//   mHBUSREQ/mHGRANT        arbiter request / grant
//   mHADDR/mHWRITE/mHTRANS  AHB address phase (registered)
//   mHWDATA/mHRDATA/HREADY  AHB data phase
//   busy                    FIFO non-empty or transfer in progress
module ahb_master_port #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mHBUSREQ,
  input  logic              mHGRANT,
  output logic [ADDR_W-1:0] mHADDR,
  output logic              mHWRITE,
  output logic [1:0]        mHTRANS,
  output logic [DATA_W-1:0] mHWDATA,
  input  logic [DATA_W-1:0] mHRDATA,
  input  logic              HREADY,
  output logic              busy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ADDR, ST_DATA} state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } entry_t;

  entry_t mem [DEPTH];

  state_t         state, state_nxt;
  logic [PTR_W:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [PTR_W-1:0] wr_idx, rd_idx, rd_idx_nxt;
  logic           empty, full, push, pop, remain, bypass;

  assign wr_idx     = wr_ptr[PTR_W-1:0];
  assign rd_idx     = rd_ptr[PTR_W-1:0];
  assign rd_idx_nxt = rd_ptr_nxt[PTR_W-1:0];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_idx == rd_idx);

  assign cmd_ready = ~full;
  assign push      = cmd_valid & ~full;
  assign pop       = (state == ST_DATA) && HREADY;

  assign wr_ptr_nxt = wr_ptr + {{PTR_W{1'b0}}, push};
  assign rd_ptr_nxt = rd_ptr + {{PTR_W{1'b0}}, pop};

  // Occupancy after this edge, counting a same-edge push.
  assign remain = (wr_ptr_nxt != rd_ptr_nxt);

  // When the only queued entry pops on the edge a new command is pushed,
  // the next head is still on the command inputs, not in the array.
  assign bypass = push && (rd_ptr_nxt == wr_ptr);

  assign busy = ~empty | (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (!empty) state_nxt = ST_REQ;
      ST_REQ:  if (mHGRANT) state_nxt = ST_ADDR;
      ST_ADDR: state_nxt = mHGRANT ? ST_DATA : ST_REQ;
      ST_DATA: if (HREADY) state_nxt = (remain && mHGRANT) ? ST_ADDR : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (push) mem[wr_idx] <= '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  end

  // AHB outputs are computed from the next state so they are plain flops
  // with no combinational path from mHGRANT or HREADY.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mHBUSREQ  <= 1'b0;
      mHTRANS   <= HTRANS_IDLE;
      mHADDR    <= '0;
      mHWRITE   <= 1'b0;
      mHWDATA   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state    <= state_nxt;
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      mHBUSREQ <= (state_nxt != ST_IDLE);
      mHTRANS  <= (state_nxt == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
      if (state_nxt == ST_ADDR) begin
        mHADDR  <= bypass ? cmd_addr  : mem[rd_idx_nxt].addr;
        mHWRITE <= bypass ? cmd_write : mem[rd_idx_nxt].write;
      end
      if ((state == ST_ADDR) && (state_nxt == ST_DATA)) mHWDATA <= mem[rd_idx].wdata;
      rsp_valid <= pop;
      if (pop) rsp_rdata <= mem[rd_idx].write ? '0 : mHRDATA;
    end
  end

endmodule
